// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and one-hot helper
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_t;

    // Sized for the largest supported requester count; callers cast down.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting just after ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            for (int j = 0; j < N; j++) begin
                if (!any && j == idx && req[j]) begin
                    winner = IW'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin share of one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                    CLKIN,
    input  logic                    RSTN,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic [IW-1:0] winner;
    logic [7:0]    burst_cnt, burst_cnt_n;
    logic          any_req;
    logic          owner_last;
    logic          xfer;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= IW'(N_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    // Datapath is a pure mux on the owner: nothing is registered, so a reset
    // can never replay a byte the requester already saw accepted.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        tx_data     = '0;
        tx_valid    = 1'b0;
        req_ready   = '0;
        owner_last  = 1'b0;
        xfer        = 1'b0;
        grant       = '0;
        busy        = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_n     = ARB_GRANTED;
                    owner_n     = winner;
                    burst_cnt_n = '0;
                end
            end
            ARB_GRANTED: begin
                busy  = 1'b1;
                grant = N_REQ'(onehot(3'(owner)));
                for (int i = 0; i < N_REQ; i++) begin
                    if (owner == IW'(i)) begin
                        tx_data      = req_data[i*DATA_W +: DATA_W];
                        tx_valid     = req_valid[i];
                        req_ready[i] = tx_ready;
                        owner_last   = req_last[i];
                    end
                end
                xfer = tx_valid && tx_ready;
                if (xfer) begin
                    burst_cnt_n = burst_cnt + 8'd1;
                    if (owner_last || burst_cnt == BURST_LAST) begin
                        state_n     = ARB_IDLE;
                        rr_ptr_n    = owner;
                        burst_cnt_n = '0;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           CLKIN = 1'b0;
    logic           RSTN;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .DATA_W    (W),
        .MAX_BURST (MB)
    ) dut (
        .CLKIN     (CLKIN),
        .RSTN      (RSTN),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] src_q[2][$];
    logic [1:0] hold;
    logic [1:0] xf;
    logic [1:0] grant_s;
    logic [1:0] rdy_s;
    logic       txv_s;
    logic [7:0] txd_s;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_src(input int lane, input logic [7:0] d, input logic last);
        src_q[lane].push_back({last, d});
    endtask

    task automatic add_exp(input logic [1:0] g, input logic [7:0] d);
        sb.push_back({g, d});
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*W +: W] = src_q[i][0][7:0];
                req_last[i]       = src_q[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*W +: W] = 8'($urandom);
                req_last[i]       = 1'b1;
            end
        end
    endtask

    // One clock: observe and score at the falling edge, advance sources after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge CLKIN);
        grant_s = grant;
        rdy_s   = req_ready;
        txv_s   = tx_valid;
        txd_s   = tx_data;
        if (tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", {24'd0, tx_data}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
                chk("grant_at_xfer", {30'd0, grant}, {30'd0, e.g});
                chk("req_ready_at_xfer", {30'd0, req_ready}, {30'd0, e.g});
            end
        end
        for (int i = 0; i < N; i++) xf[i] = req_valid[i] && req_ready[i];
        @(posedge CLKIN);
        #1;
        for (int i = 0; i < N; i++) if (xf[i]) void'(src_q[i].pop_front());
        drive_lanes();
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) step();
        chk(tag, sb.size(), 0);
    endtask

    logic [1:0] t2_trace[9]  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] t4_trace[14] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01,
                                 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic       t5_ready[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        RSTN      = 1'b0;
        hold      = '0;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge CLKIN);
        #1;
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        RSTN = 1'b1;

        // Single two-byte packet from requester 0.
        tx_ready = 1'b1;
        add_src(0, 8'h41, 1'b0);
        add_src(0, 8'h42, 1'b1);
        add_exp(2'b01, 8'h41);
        add_exp(2'b01, 8'h42);
        drive_lanes();
        step();
        chk("t1_idle_grant", {30'd0, grant_s}, 0);
        step();
        chk("t1_grant", {30'd0, grant_s}, 2'b01);
        run_until_empty("t1_drain", 20);
        step();
        chk("t1_release", {30'd0, grant_s}, 0);

        // Both lanes, one-byte packets: strict alternation with idle gaps.
        add_src(0, 8'hA0, 1'b1);
        add_src(0, 8'hA1, 1'b1);
        add_src(1, 8'hB0, 1'b1);
        add_src(1, 8'hB1, 1'b1);
        add_exp(2'b10, 8'hB0);
        add_exp(2'b01, 8'hA0);
        add_exp(2'b10, 8'hB1);
        add_exp(2'b01, 8'hA1);
        drive_lanes();
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("t2_grant_%0d", k), {30'd0, grant_s}, {30'd0, t2_trace[k]});
        end
        chk("t2_drain", sb.size(), 0);

        // Owner stalls mid-packet; the other lane must wait.
        add_src(1, 8'hC1, 1'b0);
        add_src(1, 8'hC2, 1'b0);
        add_src(1, 8'hC3, 1'b1);
        add_src(0, 8'hD0, 1'b1);
        add_exp(2'b10, 8'hC1);
        add_exp(2'b10, 8'hC2);
        add_exp(2'b10, 8'hC3);
        add_exp(2'b01, 8'hD0);
        drive_lanes();
        for (int k = 0; k < 20 && src_q[1].size() != 1; k++) step();
        chk("t3_reach_pause", src_q[1].size(), 1);
        hold[1] = 1'b1;
        drive_lanes();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_grant", {30'd0, grant_s}, 2'b10);
            chk("t3_ready0", {31'd0, rdy_s[0]}, 0);
            chk("t3_txvalid", {31'd0, txv_s}, 0);
        end
        hold[1] = 1'b0;
        drive_lanes();
        run_until_empty("t3_drain", 20);

        // Ten bytes with last only on the tenth: forced releases after 4 and 8.
        for (int i = 0; i < 10; i++) begin
            add_src(0, 8'h60 + 8'(i), i == 9);
            add_exp(2'b01, 8'h60 + 8'(i));
        end
        drive_lanes();
        for (int k = 0; k < 14; k++) begin
            step();
            chk($sformatf("t4_grant_%0d", k), {30'd0, grant_s}, {30'd0, t4_trace[k]});
        end
        chk("t4_drain", sb.size(), 0);

        // Backpressure from the transmitter during a packet.
        add_src(0, 8'hE0, 1'b0);
        add_src(0, 8'hE1, 1'b0);
        add_src(0, 8'hE2, 1'b1);
        add_exp(2'b01, 8'hE0);
        add_exp(2'b01, 8'hE1);
        add_exp(2'b01, 8'hE2);
        drive_lanes();
        step();
        chk("t5_idle", {30'd0, grant_s}, 0);
        for (int k = 0; k < 5; k++) begin
            tx_ready = t5_ready[k];
            step();
            chk("t5_grant", {30'd0, grant_s}, 2'b01);
            if (!t5_ready[k]) begin
                chk("t5_stall_data", {24'd0, txd_s}, 32'hE1);
                chk("t5_stall_ready", {30'd0, rdy_s}, 0);
            end
        end
        tx_ready = 1'b1;
        chk("t5_drain", sb.size(), 0);
        step();

        // Asynchronous reset in the middle of requester 1's packet.
        add_src(1, 8'h71, 1'b0);
        add_src(1, 8'h72, 1'b0);
        add_src(1, 8'h73, 1'b1);
        add_exp(2'b10, 8'h71);
        drive_lanes();
        step();
        step();
        chk("t6_busy_before", {31'd0, busy}, 1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_grant", {30'd0, grant}, 0);
        chk("t6_rst_txvalid", {31'd0, tx_valid}, 0);
        chk("t6_rst_ready", {30'd0, req_ready}, 0);
        chk("t6_sb_before", sb.size(), 0);
        src_q[0].delete();
        src_q[1].delete();
        sb.delete();
        @(posedge CLKIN);
        #1;
        RSTN = 1'b1;
        add_src(0, 8'h80, 1'b1);
        add_src(1, 8'h90, 1'b1);
        add_exp(2'b01, 8'h80);
        add_exp(2'b10, 8'h90);
        drive_lanes();
        run_until_empty("t6_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
